// File: rtl/hist_collector.sv
// Raw intensity histogram builder: clears the external bin RAM, accumulates one
// frame with a forwarded read-modify-write pipeline, then lends the RAM to the reader.
//
// state       | meaning
// ST_CLEAR    | write 0 to every bin, one address per cycle
// ST_WAIT_SOF | drop pixels until a valid start-of-frame pixel arrives
// ST_ACCUM    | every valid pixel enters the RMW pipeline
// ST_FLUSH    | drop pixels, drain the pipeline, latch frame statistics
// ST_READY    | histogram complete, RAM read port belongs to the reader
module hist_collector #(
  parameter int ADDR_W   = 14,
  parameter int CNT_W    = 18,
  parameter int PIXCNT_W = 24
) (
  input  logic                clk,
  input  logic                arstn,
  input  logic [ADDR_W-1:0]   pix_data,
  input  logic                pix_valid,
  input  logic                pix_sof,
  input  logic                pix_eof,
  input  logic                raw_hist_upd,
  output logic                raw_hist_rdy,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [CNT_W-1:0]    rd_dout,
  output logic [ADDR_W-1:0]   ram_rd_addr,
  input  logic [CNT_W-1:0]    ram_rd_dout,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_wr_addr,
  output logic [CNT_W-1:0]    ram_wr_din,
  output logic [PIXCNT_W-1:0] frame_pix_cnt,
  output logic                bin_sat
);

  localparam logic [ADDR_W-1:0]   ADDR_MAX = '1;
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [PIXCNT_W-1:0] PIX_MAX  = '1;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_WAIT_SOF,
    ST_ACCUM,
    ST_FLUSH,
    ST_READY
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]   clr_addr;
  logic                accept;
  logic                s1_valid;
  logic [ADDR_W-1:0]   s1_addr;
  logic [CNT_W-1:0]    s1_base;
  logic [CNT_W-1:0]    s1_inc;
  logic                s1_sat;
  logic                s3_valid;
  logic [ADDR_W-1:0]   s3_addr;
  logic [CNT_W-1:0]    s3_data;
  logic [PIXCNT_W-1:0] pix_cnt;
  logic                sat_flag;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_CLEAR: begin
        if (clr_addr == ADDR_MAX) state_nxt = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (pix_valid && pix_sof) begin
          accept    = 1'b1;
          state_nxt = pix_eof ? ST_FLUSH : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (pix_valid) begin
          accept = 1'b1;
          if (pix_eof) state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!s1_valid && !ram_we) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (raw_hist_upd) state_nxt = ST_CLEAR;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign ram_rd_addr = (state == ST_READY) ? rd_addr : pix_data;
  assign rd_dout     = (state == ST_READY) ? ram_rd_dout : '0;

  // The RAM read is one edge behind the write-back, so the newest two writes
  // (S2 in flight, S3 just committed) must override stale read data.
  always_comb begin
    s1_base = ram_rd_dout;
    if (ram_we && (ram_wr_addr == s1_addr)) begin
      s1_base = ram_wr_din;
    end else if (s3_valid && (s3_addr == s1_addr)) begin
      s1_base = s3_data;
    end
    s1_sat = (s1_base == CNT_MAX);
    s1_inc = s1_sat ? s1_base : s1_base + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state        <= ST_CLEAR;
      raw_hist_rdy <= 1'b0;
      clr_addr     <= '0;
    end else begin
      state        <= state_nxt;
      raw_hist_rdy <= (state_nxt == ST_READY);
      if (state == ST_CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
      else                   clr_addr <= '0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      s1_valid    <= 1'b0;
      s1_addr     <= '0;
      ram_we      <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_din  <= '0;
      s3_valid    <= 1'b0;
      s3_addr     <= '0;
      s3_data     <= '0;
    end else begin
      s1_valid <= accept;
      s1_addr  <= pix_data;
      if (state == ST_CLEAR) begin
        ram_we      <= 1'b1;
        ram_wr_addr <= clr_addr;
        ram_wr_din  <= '0;
      end else begin
        ram_we      <= s1_valid;
        ram_wr_addr <= s1_addr;
        ram_wr_din  <= s1_inc;
      end
      s3_valid <= ram_we;
      s3_addr  <= ram_wr_addr;
      s3_data  <= ram_wr_din;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      pix_cnt       <= '0;
      sat_flag      <= 1'b0;
      frame_pix_cnt <= '0;
      bin_sat       <= 1'b0;
    end else begin
      if (state == ST_CLEAR) begin
        pix_cnt  <= '0;
        sat_flag <= 1'b0;
      end else begin
        if (accept && (pix_cnt != PIX_MAX)) pix_cnt <= pix_cnt + PIXCNT_W'(1);
        if (s1_valid && s1_sat) sat_flag <= 1'b1;
      end
      if ((state == ST_FLUSH) && (state_nxt == ST_READY)) begin
        frame_pix_cnt <= pix_cnt;
        bin_sat       <= sat_flag;
      end
    end
  end

endmodule

// File: tb/tb_hist_collector.sv
// Directed bench: full-size collector (a) for clear sweep and reset checks,
// small collector (b, 64 bins, 4-bit counts) for forwarding, filtering and saturation.
module tb_hist_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arstn_a, arstn_b;
  logic        va, vb, sof, eof, upd_a, upd_b;
  logic [13:0] pix_data, rd_addr;
  logic [5:0]  pix_data_b, rd_addr_b;
  assign pix_data_b = pix_data[5:0];
  assign rd_addr_b  = rd_addr[5:0];

  logic        rdy_a, we_a, sat_a;
  logic [17:0] rd_dout_a, ram_rd_dout_a, wr_din_a;
  logic [13:0] ram_rd_addr_a, wr_addr_a;
  logic [23:0] fpc_a;

  logic        rdy_b, we_b, sat_b;
  logic [3:0]  rd_dout_b, ram_rd_dout_b, wr_din_b;
  logic [5:0]  ram_rd_addr_b, wr_addr_b;
  logic [23:0] fpc_b;

  hist_collector #(.ADDR_W(14), .CNT_W(18), .PIXCNT_W(24)) dut_a (
    .clk(clk), .arstn(arstn_a), .pix_data(pix_data), .pix_valid(va),
    .pix_sof(sof), .pix_eof(eof), .raw_hist_upd(upd_a), .raw_hist_rdy(rdy_a),
    .rd_addr(rd_addr), .rd_dout(rd_dout_a), .ram_rd_addr(ram_rd_addr_a),
    .ram_rd_dout(ram_rd_dout_a), .ram_we(we_a), .ram_wr_addr(wr_addr_a),
    .ram_wr_din(wr_din_a), .frame_pix_cnt(fpc_a), .bin_sat(sat_a)
  );

  hist_collector #(.ADDR_W(6), .CNT_W(4), .PIXCNT_W(24)) dut_b (
    .clk(clk), .arstn(arstn_b), .pix_data(pix_data_b), .pix_valid(vb),
    .pix_sof(sof), .pix_eof(eof), .raw_hist_upd(upd_b), .raw_hist_rdy(rdy_b),
    .rd_addr(rd_addr_b), .rd_dout(rd_dout_b), .ram_rd_addr(ram_rd_addr_b),
    .ram_rd_dout(ram_rd_dout_b), .ram_we(we_b), .ram_wr_addr(wr_addr_b),
    .ram_wr_din(wr_din_b), .frame_pix_cnt(fpc_b), .bin_sat(sat_b)
  );

  // simple dual-port RAMs, registered read returning pre-write contents
  logic [17:0] mem_a [0:16383];
  logic [3:0]  mem_b [0:63];
  always @(posedge clk) begin
    if (we_a) mem_a[wr_addr_a] <= wr_din_a;
    ram_rd_dout_a <= mem_a[ram_rd_addr_a];
    if (we_b) mem_b[wr_addr_b] <= wr_din_b;
    ram_rd_dout_b <= mem_b[ram_rd_addr_b];
  end

  int total = 0;
  int bad   = 0;

  function automatic logic get_rdy(input bit b);
    return b ? rdy_b : rdy_a;
  endfunction
  function automatic logic get_we(input bit b);
    return b ? we_b : we_a;
  endfunction
  function automatic int get_fpc(input bit b);
    return b ? int'(fpc_b) : int'(fpc_a);
  endfunction
  function automatic logic get_sat(input bit b);
    return b ? sat_b : sat_a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input bit b, input int d, input bit s, input bit e);
    pix_data = 14'(d);
    sof = s;
    eof = e;
    va = !b;
    vb = b;
    tick();
  endtask

  task automatic idle(input int n);
    va = 1'b0;
    vb = 1'b0;
    sof = 1'b0;
    eof = 1'b0;
    repeat (n) tick();
  endtask

  task automatic read_bin(input bit b, input int addr, output int val);
    rd_addr = 14'(addr);
    tick();
    val = b ? int'(rd_dout_b) : int'(rd_dout_a);
  endtask

  task automatic wait_clear(input bit b, input string nm);
    int  n;
    bit  seen;
    seen = 1'b0;
    n = 0;
    while (n < 20000) begin
      if (get_we(b)) seen = 1'b1;
      else if (seen) break;
      tick();
      n++;
    end
    total++;
    if (n >= 20000) begin
      bad++;
      $display("FAIL %s clear_done: waited %0d cycles, want clear sweep to finish", nm, n);
    end
  endtask

  task automatic wait_rdy(input bit b, input string nm);
    int n;
    n = 0;
    while (!get_rdy(b) && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL %s rdy_rise: waited %0d cycles, want raw_hist_rdy=1", nm, n);
    end
  endtask

  task automatic test_reset();
    arstn_a = 1'b1; arstn_b = 1'b1;
    va = 0; vb = 0; sof = 0; eof = 0; upd_a = 0; upd_b = 0;
    pix_data = '0; rd_addr = '0;
    #2;
    arstn_a = 1'b0; arstn_b = 1'b0;
    repeat (3) tick();
    for (int b = 0; b < 2; b++) begin
      total++; if (get_rdy(b[0]) !== 1'b0) begin bad++; $display("FAIL reset_rdy[%0d]: got %b want 0", b, get_rdy(b[0])); end
      total++; if (get_we(b[0]) !== 1'b0) begin bad++; $display("FAIL reset_we[%0d]: got %b want 0", b, get_we(b[0])); end
      total++; if (get_fpc(b[0]) != 0) begin bad++; $display("FAIL reset_fpc[%0d]: got %0d want 0", b, get_fpc(b[0])); end
      total++; if (get_sat(b[0]) !== 1'b0) begin bad++; $display("FAIL reset_sat[%0d]: got %b want 0", b, get_sat(b[0])); end
    end
    arstn_a = 1'b1; arstn_b = 1'b1;
    tick();
  endtask

  task automatic test_forwarding();
    int v;
    int seq[5] = '{7, 9, 7, 9, 7};
    wait_clear(1, "fwd");
    for (int i = 0; i < 5; i++) drive_pix(1, seq[i], i == 0, i == 4);
    idle(1);
    wait_rdy(1, "fwd_b2b");
    read_bin(1, 7, v);
    total++; if (v != 3) begin bad++; $display("FAIL fwd_b2b_bin7: got %0d want 3", v); end
    read_bin(1, 9, v);
    total++; if (v != 2) begin bad++; $display("FAIL fwd_b2b_bin9: got %0d want 2", v); end
    read_bin(1, 8, v);
    total++; if (v != 0) begin bad++; $display("FAIL fwd_b2b_bin8: got %0d want 0", v); end
    total++; if (get_fpc(1) != 5) begin bad++; $display("FAIL fwd_b2b_fpc: got %0d want 5", get_fpc(1)); end
    upd_b = 1'b1;
    tick();
    upd_b = 1'b0;
    total++; if (rdy_b !== 1'b0) begin bad++; $display("FAIL fwd_upd_rdy: got %b want 0", rdy_b); end
    wait_clear(1, "fwd_gap");
    seq = '{7, 7, 7, 9, 9};
    for (int i = 0; i < 5; i++) begin
      drive_pix(1, seq[i], i == 0, i == 4);
      idle(1);
    end
    wait_rdy(1, "fwd_gap");
    read_bin(1, 7, v);
    total++; if (v != 3) begin bad++; $display("FAIL fwd_gap_bin7: got %0d want 3", v); end
    read_bin(1, 9, v);
    total++; if (v != 2) begin bad++; $display("FAIL fwd_gap_bin9: got %0d want 2", v); end
  endtask

  task automatic test_sof_eof_filter();
    int v;
    upd_b = 1'b1;
    tick();
    upd_b = 1'b0;
    wait_clear(1, "filt");
    drive_pix(1, 11, 0, 0);
    drive_pix(1, 12, 0, 1);
    idle(1);
    for (int i = 0; i < 10; i++) drive_pix(1, (i < 5) ? 11 : 12, (i == 0) || (i == 4), i == 9);
    for (int i = 0; i < 3; i++) drive_pix(1, 11, 0, 0);
    idle(1);
    wait_rdy(1, "filt");
    read_bin(1, 11, v);
    total++; if (v != 5) begin bad++; $display("FAIL filt_bin11: got %0d want 5", v); end
    read_bin(1, 12, v);
    total++; if (v != 5) begin bad++; $display("FAIL filt_bin12: got %0d want 5", v); end
    total++; if (get_fpc(1) != 10) begin bad++; $display("FAIL filt_fpc: got %0d want 10", get_fpc(1)); end
  endtask

  task automatic test_saturation();
    int v;
    upd_b = 1'b1;
    tick();
    upd_b = 1'b0;
    wait_clear(1, "sat");
    for (int i = 0; i < 20; i++) drive_pix(1, 3, i == 0, i == 19);
    idle(1);
    wait_rdy(1, "sat");
    read_bin(1, 3, v);
    total++; if (v != 15) begin bad++; $display("FAIL sat_bin3: got %0d want 15", v); end
    total++; if (sat_b !== 1'b1) begin bad++; $display("FAIL sat_flag: got %b want 1", sat_b); end
    total++; if (get_fpc(1) != 20) begin bad++; $display("FAIL sat_fpc: got %0d want 20", get_fpc(1)); end
    upd_b = 1'b1;
    tick();
    upd_b = 1'b0;
    total++; if (sat_b !== 1'b1) begin bad++; $display("FAIL sat_hold: got %b want 1", sat_b); end
    wait_clear(1, "nosat");
    drive_pix(1, 3, 1, 0);
    drive_pix(1, 3, 0, 1);
    idle(1);
    wait_rdy(1, "nosat");
    read_bin(1, 3, v);
    total++; if (v != 2) begin bad++; $display("FAIL nosat_bin3: got %0d want 2", v); end
    total++; if (sat_b !== 1'b0) begin bad++; $display("FAIL nosat_flag: got %b want 0", sat_b); end
    upd_b = 1'b1;
    tick();
    upd_b = 1'b0;
    wait_clear(1, "single");
    drive_pix(1, 6, 1, 1);
    idle(1);
    wait_rdy(1, "single");
    read_bin(1, 6, v);
    total++; if (v != 1) begin bad++; $display("FAIL single_bin6: got %0d want 1", v); end
    total++; if (get_fpc(1) != 1) begin bad++; $display("FAIL single_fpc: got %0d want 1", get_fpc(1)); end
  endtask

  task automatic test_back_to_back();
    int v;
    wait_clear(0, "b2b");
    for (int i = 0; i < 4; i++) drive_pix(0, 5, i == 0, i == 3);
    idle(1);
    wait_rdy(0, "b2b");
    read_bin(0, 5, v);
    total++; if (v != 4) begin bad++; $display("FAIL b2b_bin5: got %0d want 4", v); end
    read_bin(0, 4, v);
    total++; if (v != 0) begin bad++; $display("FAIL b2b_bin4: got %0d want 0", v); end
    read_bin(0, 6, v);
    total++; if (v != 0) begin bad++; $display("FAIL b2b_bin6: got %0d want 0", v); end
    total++; if (fpc_a != 24'd4) begin bad++; $display("FAIL b2b_fpc: got %0d want 4", fpc_a); end
    total++; if (sat_a !== 1'b0) begin bad++; $display("FAIL b2b_sat: got %b want 0", sat_a); end
  endtask

  task automatic test_upd_held();
    int v;
    int errs;
    int seq[4] = '{1, 2, 2, 3};
    upd_a = 1'b1;
    tick();
    total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL held_rdy_fall: got %b want 0", rdy_a); end
    total++; if (rd_dout_a !== '0) begin bad++; $display("FAIL held_rd_dout: got %0d want 0", rd_dout_a); end
    errs = 0;
    for (int i = 0; i < 16384; i++) begin
      tick();
      if (we_a !== 1'b1 || int'(wr_addr_a) != i || wr_din_a !== '0) begin
        if (errs < 4) $display("FAIL held_sweep[%0d]: got we=%b addr=%0d din=%0d want we=1 addr=%0d din=0", i, we_a, wr_addr_a, wr_din_a, i);
        errs++;
      end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL held_sweep: got %0d bad cycles want 0", errs); end
    tick();
    total++; if (we_a !== 1'b0) begin bad++; $display("FAIL held_sweep_end: got we=%b want 0", we_a); end
    for (int i = 0; i < 4; i++) drive_pix(0, seq[i], i == 0, i == 3);
    idle(1);
    upd_a = 1'b0;
    wait_rdy(0, "held");
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rdy_a !== 1'b1) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL held_rdy_stay: got %0d low cycles want 0", errs); end
    read_bin(0, 2, v);
    total++; if (v != 2) begin bad++; $display("FAIL held_bin2: got %0d want 2", v); end
    total++; if (fpc_a != 24'd4) begin bad++; $display("FAIL held_fpc: got %0d want 4", fpc_a); end
    upd_a = 1'b1;
    tick();
    upd_a = 1'b0;
    total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL held_rdy_refall: got %b want 0", rdy_a); end
  endtask

  task automatic test_async_reset();
    int v;
    wait_clear(0, "arst");
    for (int i = 0; i < 3; i++) drive_pix(0, 100, i == 0, 0);
    total++; if (we_a !== 1'b1) begin bad++; $display("FAIL arst_pre_we: got %b want 1", we_a); end
    arstn_a = 1'b0;
    va = 1'b0;
    #1;
    total++; if (we_a !== 1'b0) begin bad++; $display("FAIL arst_we: got %b want 0", we_a); end
    total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL arst_rdy: got %b want 0", rdy_a); end
    total++; if (fpc_a != 24'd0) begin bad++; $display("FAIL arst_fpc: got %0d want 0", fpc_a); end
    tick();
    arstn_a = 1'b1;
    tick();
    wait_clear(0, "arst_post");
    drive_pix(0, 200, 1, 1);
    idle(1);
    wait_rdy(0, "arst_post");
    read_bin(0, 100, v);
    total++; if (v != 0) begin bad++; $display("FAIL arst_bin100: got %0d want 0", v); end
    read_bin(0, 200, v);
    total++; if (v != 1) begin bad++; $display("FAIL arst_bin200: got %0d want 1", v); end
    total++; if (fpc_a != 24'd1) begin bad++; $display("FAIL arst_fpc_post: got %0d want 1", fpc_a); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_sof_eof_filter();
    test_saturation();
    test_back_to_back();
    test_upd_held();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hist_collector.md
Name: hist_collector

Overview:
- Builds the raw 14-bit intensity histogram from the sensor pixel stream into the raw histogram RAM (simple dual port, 16384 x 18).
- Hands the finished histogram to hist_rebuilder for read-only use through the raw_hist_upd/raw_hist_rdy handshake.
- Owns the RAM and arbitrates it: clears it, accumulates with read-modify-write, then muxes the rebuilder's read port onto it.

Parameters:
ADDR_W, 14, pixel/bin address width; RAM depth = 2^ADDR_W
CNT_W, 18, bin counter width; bins saturate at 2^CNT_W-1
PIXCNT_W, 24, width of per-frame accepted-pixel counter

Ports:
clk  in  1  clock
arstn  in  1  asynchronous active-low reset
pix_data  in  ADDR_W  pixel intensity (bin index)
pix_valid  in  1  pixel qualifier; no backpressure, may be high every cycle
pix_sof  in  1  first pixel of frame (qualified by pix_valid)
pix_eof  in  1  last pixel of frame (qualified by pix_valid)
raw_hist_upd  in  1  rebuilder request for a fresh histogram
raw_hist_rdy  out  1  histogram complete, RAM owned by reader
rd_addr  in  ADDR_W  reader bin address
rd_dout  out  CNT_W  reader bin data, 1-cycle latency
ram_rd_addr  out  ADDR_W  RAM read address
ram_rd_dout  in  CNT_W  RAM read data, 1-cycle latency
ram_we  out  1  RAM write enable
ram_wr_addr  out  ADDR_W  RAM write address
ram_wr_din  out  CNT_W  RAM write data
frame_pix_cnt  out  PIXCNT_W  pixels accumulated in last completed frame
bin_sat  out  1  any bin saturated during last completed frame

Behaviour:
- Reset: asserted at any time, asynchronously forces ST_CLEAR with clear address 0; raw_hist_rdy=0, ram_we=0, frame_pix_cnt=0, bin_sat=0 and all pipeline valids 0. Deassertion is synchronised upstream.
- ST_CLEAR:
  - Writes 0 to addresses 0..2^ADDR_W-1, one per cycle (16384 cycles).
  - After the last address is written, goes to ST_WAIT_SOF.
  - Pixels and raw_hist_upd are ignored.
- ST_WAIT_SOF:
  - Waits for pix_valid&pix_sof. That pixel is counted and the state becomes ST_ACCUM.
  - Pixels seen before sof are dropped, so a partial frame is never collected.
- ST_ACCUM:
  - Every pix_valid pixel enters a 3-stage RMW pipeline: S0 drives ram_rd_addr=pix_data; S1 captures the count and adds 1; S2 writes it back.
  - Throughput is one pixel per cycle.
  - Back-to-back or interleaved equal bins must count exactly. S1 forwards in-flight S2 write data when addresses match, instead of stale RAM data.
  - Increments saturate at 2^CNT_W-1; a saturating increment sets an internal sat flag.
  - A pixel with pix_eof (a sof+eof pixel is a 1-pixel frame) is counted and the state goes to ST_FLUSH.
  - pix_sof inside ST_ACCUM is counted as an ordinary pixel.
- ST_FLUSH:
  - Waits until the pipeline is empty (the last write issued). Pixels arriving meanwhile are dropped.
  - Latches frame_pix_cnt and bin_sat, then goes to ST_READY.
  - The internal pixel counter saturates at 2^PIXCNT_W-1.
- ST_READY:
  - raw_hist_rdy=1, registered.
  - ram_rd_addr=rd_addr combinationally; rd_dout=ram_rd_dout. No writes occur.
  - raw_hist_upd=1 moves to ST_CLEAR; raw_hist_rdy is 0 from the next cycle.
  - The internal counter and sat flag are reset, but frame_pix_cnt and bin_sat hold until the next ST_FLUSH.
- Outside ST_READY: rd_dout=0 and raw_hist_upd is ignored. The rebuilder holds upd high until it sees rdy low; that is legal.
- Cycle timing: upd sampled high in ST_READY takes one cycle to rdy low. Clear starts the same cycle; the first zero write (addr 0) occurs one cycle after rdy falls.
- Transitions: ST_CLEAR -> ST_WAIT_SOF -> ST_ACCUM -> ST_FLUSH -> ST_READY -> ST_CLEAR.

Test Plan:
1. Reset, then 16384 clear cycles, frame of 4 pixels {5,5,5,5} back-to-back -> after rdy=1, read bin5=4, bin4=0, bin6=0, frame_pix_cnt=4, bin_sat=0.
2. Frame {7,9,7,9,7} every cycle, then a frame with gaps of 1 cycle -> bin7=3, bin9=2 in both cases (forwarding correct at distance 1 and 2).
3. Pixels before sof, then a 10-pixel frame, then pixels after eof while rdy=0 -> only the 10 counted, frame_pix_cnt=10.
4. Hold raw_hist_upd=1 continuously -> rdy drops 1 cycle after READY, ram_we high with addresses 0..16383, next frame collected, rdy rises, stays high until upd is seen again.
5. Use CNT_W=4 and send 20 pixels of value 3 -> bin3=15, bin_sat=1; next frame without saturation -> bin_sat=0.
6. Assert arstn=0 mid-ACCUM -> rdy=0 and ram_we=0 immediately, a full clear follows, old bins read 0 after the next frame.
